// File: rtl/bfs_pkg.sv
// Shared constants and types for the level-synchronous BFS scheduler.
package bfs_pkg;

  localparam int WORD_W = 512;
  localparam int TH_W   = 32;

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_INIT = 2'b01;
  localparam logic [1:0] CTRL_RUN  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_REQ    = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Pipeline control code presented while the scheduler sits in a state.
  function automatic logic [1:0] ctrl_for_state(input state_e s);
    logic [1:0] c;
    c = CTRL_IDLE;
    case (s)
      ST_INIT:                               c = CTRL_INIT;
      ST_REQ, ST_STREAM, ST_DRAIN, ST_CHECK: c = CTRL_RUN;
      default:                               c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bfs_level_sched_watchdog.sv
// Drain watchdog: counts enabled cycles and flags expiry at TIMEOUT.
// Only instantiated when BFS_SCHED_TIMEOUT_EN is defined.
module bfs_sched_watchdog
  import bfs_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt_q <= '0;
    end else if (enable && cnt_q != LIMIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The TIMEOUT-th enabled cycle is the one that expires.
  assign expire = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/bfs_level_sched.sv
// Level-synchronous BFS scheduler driving one bfs_pipeline instance.
// Optional drain watchdog enabled by defining BFS_SCHED_TIMEOUT_EN.
module bfs_level_sched
  import bfs_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int MAX_LEVEL = 255,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] src_word,
  input  logic              src_valid,
  input  logic              src_last,
  output logic              src_ready,
  output logic              scan_req,
  output logic [WORD_W-1:0] pipe_word,
  output logic              pipe_word_valid,
  output logic [TH_W-1:0]   pipe_word_th,
  output logic              pipe_last,
  output logic [1:0]        pipe_control,
  output logic [7:0]        pipe_level,
  input  logic              pipe_valid_in,
  input  logic              pipe_last_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        final_level,
  output logic [31:0]       level_updates
);

  localparam logic [ADDR_W-1:0] INIT_LAST = '1;
  localparam logic [7:0]        MAX_LVL   = 8'(MAX_LEVEL);
  localparam logic [31:0]       UPD_SAT   = 32'hFFFF_FFFF;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [7:0]        level_q, level_d;
  logic [TH_W-1:0]   tag_q, tag_d;
  logic [31:0]       upd_q, upd_d;
  logic              err_q, err_d;
  logic [7:0]        final_level_q, final_level_d;
  logic [7:0]        pipe_level_q, pipe_level_d;

  logic [WORD_W-1:0] pipe_word_q;
  logic              pipe_word_valid_q;
  logic [TH_W-1:0]   pipe_th_q;
  logic              pipe_last_q;
  logic [1:0]        pipe_control_q;
  logic              src_ready_q;
  logic              scan_req_q;
  logic              done_q;

  logic handshake;
  logic counting;
  logic wd_expire;

  // Source handshake: a word moves when src_valid and src_ready are both high
  // at a rising edge; src_ready is registered and high only in STREAM.
  assign handshake = src_valid && src_ready_q;
  assign counting  = (state_q == ST_STREAM) || (state_q == ST_DRAIN);

`ifdef BFS_SCHED_TIMEOUT_EN
  bfs_sched_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q != ST_DRAIN),
    .enable(state_q == ST_DRAIN),
    .expire(wd_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign wd_expire      = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    level_d       = level_q;
    tag_d         = tag_q;
    upd_d         = upd_q;
    err_d         = err_q;
    final_level_d = final_level_q;
    pipe_level_d  = pipe_level_q;

    // Counted before the FSM decision so a coincident last_in sees it in CHECK.
    if (counting && pipe_valid_in && upd_q != UPD_SAT) begin
      upd_d = upd_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d         = 1'b0;
          final_level_d = 8'd0;
          upd_d         = 32'd0;
          level_d       = 8'd1;
          init_cnt_d    = '0;
          pipe_level_d  = 8'd0;
          state_d       = ST_INIT;
        end
      end
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          pipe_level_d = level_q;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        tag_d   = '0;
        upd_d   = 32'd0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (handshake) begin
          tag_d = tag_q + TH_W'(1);
          if (src_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_last_in) begin
          state_d = ST_CHECK;
        end else if (wd_expire) begin
          err_d         = 1'b1;
          final_level_d = level_q;
          state_d       = ST_DONE;
        end
      end
      ST_CHECK: begin
        if (upd_q == 32'd0 || level_q == MAX_LVL) begin
          final_level_d = level_q;
          state_d       = ST_DONE;
        end else begin
          level_d      = level_q + 8'd1;
          pipe_level_d = level_q + 8'd1;
          state_d      = ST_REQ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= ST_IDLE;
      init_cnt_q        <= '0;
      level_q           <= 8'd0;
      tag_q             <= '0;
      upd_q             <= 32'd0;
      err_q             <= 1'b0;
      final_level_q     <= 8'd0;
      pipe_level_q      <= 8'd0;
      pipe_word_q       <= '0;
      pipe_word_valid_q <= 1'b0;
      pipe_th_q         <= '0;
      pipe_last_q       <= 1'b0;
      pipe_control_q    <= CTRL_IDLE;
      src_ready_q       <= 1'b0;
      scan_req_q        <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      init_cnt_q        <= init_cnt_d;
      level_q           <= level_d;
      tag_q             <= tag_d;
      upd_q             <= upd_d;
      err_q             <= err_d;
      final_level_q     <= final_level_d;
      pipe_level_q      <= pipe_level_d;
      pipe_word_valid_q <= handshake;
      pipe_last_q       <= handshake && src_last;
      if (handshake) begin
        pipe_word_q <= src_word;
        pipe_th_q   <= tag_q;
      end
      // Status strobes are registered from the next state so they line up with it.
      pipe_control_q <= ctrl_for_state(state_d);
      src_ready_q    <= (state_d == ST_STREAM);
      scan_req_q     <= (state_d == ST_REQ);
      done_q         <= (state_d == ST_DONE);
    end
  end

  assign src_ready       = src_ready_q;
  assign scan_req        = scan_req_q;
  assign pipe_word       = pipe_word_q;
  assign pipe_word_valid = pipe_word_valid_q;
  assign pipe_word_th    = pipe_th_q;
  assign pipe_last       = pipe_last_q;
  assign pipe_control    = pipe_control_q;
  assign pipe_level      = pipe_level_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign err             = err_q;
  assign final_level     = final_level_q;
  assign level_updates   = upd_q;

endmodule

// File: tb/tb_bfs_level_sched.sv
// Self-checking bench for bfs_level_sched: table-driven runs, random runs
// against a transaction-level model, and hand-written reset/watchdog sequences.
module tb_bfs_level_sched;
  import bfs_pkg::*;

  localparam int ADDR_W    = 4;
  localparam int MAX_LEVEL = 3;
  localparam int TIMEOUT   = 8;
  localparam int SB_W      = 1 + TH_W + WORD_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WORD_W-1:0] src_word;
  logic              src_valid;
  logic              src_last;
  logic              src_ready;
  logic              scan_req;
  logic [WORD_W-1:0] pipe_word;
  logic              pipe_word_valid;
  logic [TH_W-1:0]   pipe_word_th;
  logic              pipe_last;
  logic [1:0]        pipe_control;
  logic [7:0]        pipe_level;
  logic              pipe_valid_in;
  logic              pipe_last_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        final_level;
  logic [31:0]       level_updates;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] mon_got, mon_exp;
  int lvl_upd [1:MAX_LEVEL];

  typedef struct {
    int u1;
    int u2;
    int u3;
    int nwords;
    bit coin;
    int exp_final;
  } vec_t;
  vec_t vecs[7];

  bfs_level_sched #(
    .ADDR_W   (ADDR_W),
    .MAX_LEVEL(MAX_LEVEL),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .src_word       (src_word),
    .src_valid      (src_valid),
    .src_last       (src_last),
    .src_ready      (src_ready),
    .scan_req       (scan_req),
    .pipe_word      (pipe_word),
    .pipe_word_valid(pipe_word_valid),
    .pipe_word_th   (pipe_word_th),
    .pipe_last      (pipe_last),
    .pipe_control   (pipe_control),
    .pipe_level     (pipe_level),
    .pipe_valid_in  (pipe_valid_in),
    .pipe_last_in   (pipe_last_in),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .final_level    (final_level),
    .level_updates  (level_updates)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: got no end of test, required end within 40000 cycles");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp_v);
    end
  endtask

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] w;
    for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Reference: the run ends on the first level with no updates, else at MAX_LEVEL.
  function automatic int model_final();
    for (int l = 1; l <= MAX_LEVEL; l++) begin
      if (lvl_upd[l] == 0) return l;
    end
    return MAX_LEVEL;
  endfunction

  // Scoreboard: every forwarded word must match the next accepted source word.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (pipe_word_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pipe_word_unexpected: got tag %0d, required no word", pipe_word_th);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_got = {pipe_last, pipe_word_th, pipe_word};
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL pipe_word: got last=%0b tag=%0d w=%h required last=%0b tag=%0d w=%h",
                     mon_got[SB_W-1], mon_got[WORD_W +: TH_W], mon_got[WORD_W-1:0],
                     mon_exp[SB_W-1], mon_exp[WORD_W +: TH_W], mon_exp[WORD_W-1:0]);
          end
        end
      end else if (pipe_last) begin
        n_checks++;
        n_fail++;
        $display("FAIL pipe_last_stray: got 1 required 0");
      end
    end
  end

  // Driver: start pulse, then INIT length and first scan request.
  task automatic start_run();
    int n_init;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("final_level_cleared", final_level, 0);
    check("err_cleared", err, 0);
    check("updates_cleared_on_start", level_updates, 0);
    check("init_level", pipe_level, 0);
    n_init = 0;
    while (pipe_control == CTRL_INIT && n_init < 64) begin
      n_init++;
      @(negedge clk);
    end
    check("init_cycles", n_init, 1 << ADDR_W);
    check("scan_req_pulse", scan_req, 1);
  endtask

  // Driver: one level, entered at the negedge of the REQ cycle.
  task automatic run_level(input int lvl, input int nupd, input int nwords, input bit coin,
                           input bit exp_last, output bit got_done);
    int remaining, sent, cyc, k, min_k;
    bit pv, pl, fin;
    logic [WORD_W-1:0] w;
    check("level_at_req", pipe_level, lvl);
    check("ready_low_in_req", src_ready, 0);
    tick();
    remaining = nupd;
    sent = 0;
    cyc = 0;
    while (sent < nwords && cyc < 200) begin
      w = rand_word();
      src_word  = w;
      src_valid = ($urandom_range(0, 3) != 0);
      src_last  = (sent == nwords - 1);
      pipe_valid_in = !coin && (remaining > 0) && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (cyc == 0) begin
        check("ready_in_stream", src_ready, 1);
        check("control_run", pipe_control, CTRL_RUN);
        check("updates_cleared_at_req", level_updates, 0);
      end
      if (src_valid && src_ready) begin
        exp_q.push_back({src_last, TH_W'(sent), w});
        sent++;
      end
      if (pipe_valid_in) remaining--;
      tick();
      cyc++;
    end
    pipe_valid_in = 1'b0;
    min_k = coin ? 0 : $urandom_range(0, 3);
    k = 0;
    fin = 1'b0;
    while (!fin && k < 64) begin
      pv = (remaining > 0) && ($urandom_range(0, 2) != 0);
      pl = ((remaining - int'(pv)) == 0) && (coin || !pv) && (k >= min_k);
      pipe_valid_in = pv;
      pipe_last_in  = pl;
      src_valid = $urandom_range(0, 1);
      src_word  = rand_word();
      src_last  = $urandom_range(0, 1);
      start     = (k == 0);
      @(negedge clk);
      if (k == 0) check("ready_low_in_drain", src_ready, 0);
      if (pv) remaining--;
      fin = pl;
      tick();
      k++;
    end
    pipe_valid_in = 1'b0;
    pipe_last_in  = 1'b0;
    src_valid = 1'b0;
    src_last  = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check("level_updates", level_updates, nupd);
    check("no_done_in_check", done, 0);
    tick();
    @(negedge clk);
    got_done = done;
    if (exp_last) begin
      check("done_pulse", done, 1);
      check("final_level", final_level, lvl);
      check("no_scan_after_last", scan_req, 0);
    end else begin
      check("scan_req_next_level", scan_req, 1);
      check("done_early", done, 0);
      check("level_advance", pipe_level, lvl + 1);
    end
  endtask

  task automatic do_run(input int u1, input int u2, input int u3, input int nwords,
                        input bit coin, input int exp_final);
    int lvl, nw;
    bit got_done;
    lvl_upd[1] = u1;
    lvl_upd[2] = u2;
    lvl_upd[3] = u3;
    start_run();
    lvl = 1;
    got_done = 1'b0;
    while (!got_done && lvl <= MAX_LEVEL) begin
      nw = (nwords > 0) ? nwords : $urandom_range(1, 4);
      run_level(lvl, lvl_upd[lvl], nw, coin, lvl == exp_final, got_done);
      if (!got_done) lvl++;
    end
    check("levels_run", lvl, exp_final);
    tick();
    pipe_valid_in = 1'b1;
    tick();
    tick();
    pipe_valid_in = 1'b0;
    @(negedge clk);
    check("idle_not_busy", busy, 0);
    check("idle_updates_held", level_updates, lvl_upd[exp_final]);
    check("final_level_held", final_level, exp_final);
    check("err_clear", err, 0);
  endtask

`ifdef BFS_SCHED_TIMEOUT_EN
  logic [WORD_W-1:0] wd_w;
  int wd_n;
`endif

  initial begin
    rst = 1'b0;
    start = 1'b0;
    src_word = '0;
    src_valid = 1'b0;
    src_last = 1'b0;
    pipe_valid_in = 1'b0;
    pipe_last_in = 1'b0;

    vecs[0] = '{5, 0, 0, 3, 1'b0, 2};
    vecs[1] = '{2, 3, 4, 0, 1'b0, 3};
    vecs[2] = '{0, 7, 7, 1, 1'b0, 1};
    vecs[3] = '{1, 0, 9, 2, 1'b1, 2};
    vecs[4] = '{1, 1, 0, 0, 1'b1, 3};
    vecs[5] = '{6, 4, 2, 4, 1'b1, 3};
    vecs[6] = '{3, 0, 0, 1, 1'b0, 2};

    repeat (3) tick();
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_control", pipe_control, CTRL_IDLE);
    check("reset_updates", level_updates, 0);
    check("reset_final_level", final_level, 0);
    check("reset_err", err, 0);
    check("reset_word_valid", pipe_word_valid, 0);
    check("reset_ready", src_ready, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      do_run(vecs[i].u1, vecs[i].u2, vecs[i].u3, vecs[i].nwords, vecs[i].coin, vecs[i].exp_final);
    end

    // Reset in the middle of a level aborts with no done pulse.
    start_run();
    tick();
    src_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_control", pipe_control, CTRL_IDLE);
    check("midrst_level", pipe_level, 0);
    check("midrst_final_level", final_level, 0);
    check("midrst_updates", level_updates, 0);
    check("midrst_word", |pipe_word, 0);
    check("midrst_tag", pipe_word_th, 0);
    check("midrst_ready", src_ready, 0);
    check("midrst_scan_req", scan_req, 0);
    check("midrst_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end

    for (int i = 0; i < 8; i++) begin
      for (int l = 1; l <= MAX_LEVEL; l++) begin
        lvl_upd[l] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6);
      end
      do_run(lvl_upd[1], lvl_upd[2], lvl_upd[3], 0, $urandom_range(0, 1), model_final());
    end

`ifdef BFS_SCHED_TIMEOUT_EN
    start_run();
    tick();
    wd_w = rand_word();
    src_word = wd_w;
    src_valid = 1'b1;
    src_last = 1'b1;
    @(negedge clk);
    if (src_ready) exp_q.push_back({1'b1, TH_W'(0), wd_w});
    tick();
    src_valid = 1'b0;
    src_last = 1'b0;
    wd_n = 0;
    @(negedge clk);
    while (!done && wd_n < 64) begin
      tick();
      @(negedge clk);
      wd_n++;
    end
    check("wd_done_delay", wd_n, TIMEOUT);
    check("wd_err", err, 1);
    check("wd_final_level", final_level, 1);
    tick();
    do_run(0, 0, 0, 2, 1'b0, 1);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bfs_level_sched.md
# bfs_level_sched

Level-synchronous BFS scheduler that sequences one `bfs_pipeline` instance. It initialises the pipeline's vertex BRAMs, and per BFS level requests an edge scan, streams 512-bit edge words into the pipeline with sequence tags and drives `control`/`current_level`. It waits for the pipeline to drain, counts vertex updates, and then either advances the level or terminates. It sits between the edge-stream reader (AFU I/O side) and the pipeline head.

## Interface
- `ADDR_W`, 4: pipeline BRAM address width; the INIT phase lasts `2**ADDR_W` cycles.
- `MAX_LEVEL`, 255: last level processed; range 1..255.
- `TIMEOUT`, 4096: drain watchdog limit in cycles (used only with the macro).

Ports (clock and reset first):
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a BFS run; ignored unless in IDLE.
- `src_word` in 512: edge word from the reader.
- `src_valid` in 1: `src_word` is valid.
- `src_last` in 1: final word of the scan, qualified by `src_valid`.
- `src_ready` out 1: scheduler accepts `src_word`.
- `scan_req` out 1: one-cycle pulse telling the reader to restart the edge scan.
- `pipe_word` out 512: word to the pipeline `word_in`.
- `pipe_word_valid` out 1: to `word_in_valid`.
- `pipe_word_th` out 32: to `word_in_th`; sequence index within the level.
- `pipe_last` out 1: to `last_input_in`.
- `pipe_control` out 2: to `control`.
- `pipe_level` out 8: to `current_level`.
- `pipe_valid_in` in 1: from the pipeline `valid_out`; one vertex update.
- `pipe_last_in` in 1: from the pipeline `last_input_out`; drain complete.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at termination.
- `err` out 1: sticky watchdog error, cleared by `start`.
- `final_level` out 8: last level processed; held until the next `start`.
- `level_updates` out 32: saturating update count for the current or most recent level.

## Operation
- Control codes:
  - `CTRL_IDLE` = 2'b00
  - `CTRL_INIT` = 2'b01
  - `CTRL_RUN` = 2'b10
- FSM states:
  - **IDLE:** `pipe_control` = IDLE. On `start`: clear `err`, `final_level`, `level_updates`; set level to 1; go to INIT.
  - **INIT:** `pipe_control` = INIT for exactly `2**ADDR_W` cycles; `pipe_level` = 0. Then go to REQ.
  - **REQ:** pulse `scan_req` for 1 cycle; clear the tag counter and `level_updates`; go to STREAM.
  - **STREAM:** `src_ready` = 1; `pipe_control` = RUN.
    - Each handshake (`src_valid` && `src_ready`) registers `src_word` to `pipe_word` with `pipe_word_valid` = 1 and `pipe_word_th` = tag, then increments the tag (32-bit wrap).
    - A handshake with `src_last` = 1 also sets `pipe_last` = 1 and moves to DRAIN.
  - **DRAIN:** `src_ready` = 0; `pipe_control` stays RUN. When `pipe_last_in` = 1, go to CHECK.
  - **CHECK (1 cycle):**
    - If `level_updates` == 0 or level == `MAX_LEVEL`: `final_level` = level; go to DONE.
    - Otherwise: level + 1; go to REQ.
  - **DONE:** pulse `done` for 1 cycle; go to IDLE.
- Update counting:
  - `pipe_valid_in` is counted only in STREAM and DRAIN; it is ignored elsewhere.
  - The counter saturates at 32'hFFFF_FFFF.
  - If `pipe_valid_in` and `pipe_last_in` arrive in the same cycle, the update is counted before the CHECK decision.
- A source word arriving while `src_ready` = 0 is not consumed.
- A `start` arriving while `busy` is ignored.
- An empty level (`src_last` on the first beat) is legal: that one word is forwarded and the normal drain follows.

## Timing
- Reset values (while `rst` = 0 at a clock edge):
  - state = IDLE.
  - All outputs 0: `pipe_word`, `pipe_word_th`, `pipe_level`, `pipe_control` (= IDLE), `final_level`, `level_updates`, `err`.
- Reset asserted mid-run aborts immediately, with no `done` pulse.
- `pipe_*` outputs are registered. A word accepted at edge N appears on `pipe_*` after edge N and is valid for exactly 1 cycle. `pipe_word_valid` and `pipe_last` are 0 in every other cycle.
- `src_ready` is a registered function of state; it deasserts in the cycle after the `src_last` handshake.
- `pipe_level` is updated in the cycle the FSM leaves CHECK and is stable throughout REQ, STREAM and DRAIN.
- Minimum inter-level gap: CHECK → REQ → STREAM = 2 cycles between the `pipe_last_in` cycle and the next `src_ready`.
- `done` is asserted 2 cycles after the `pipe_last_in` that ends the final level.

## Configuration
- `BFS_SCHED_TIMEOUT_EN`:
  - **Defined:** a cycle counter runs in DRAIN. On reaching `TIMEOUT` without `pipe_last_in`, set `err` = 1, set `final_level` = level, and go to DONE (`done` still pulses).
  - **Undefined:** there is no counter, DRAIN waits indefinitely, and `err` is tied to 0.

## Structure
- Package `bfs_pkg` holds:
  - the `CTRL_*` constants;
  - the FSM state enum (IDLE, INIT, REQ, STREAM, DRAIN, CHECK, DONE);
  - `WORD_W` = 512 and `TH_W` = 32.
- One sub-module, `bfs_sched_watchdog` (clear, enable, expire output), is instantiated only under `BFS_SCHED_TIMEOUT_EN`.
- All other logic lives in a single FSM file.

## Test plan
- **Reset mid-STREAM:** hold `rst` = 0 for 1 cycle → next cycle state IDLE, all outputs 0, no `done`.
- **Full run, ADDR_W = 4:**
  - `start` → `pipe_control` = 01 for 16 cycles, then a `scan_req` pulse.
  - Stream 3 words → `pipe_word_th` = 0, 1, 2, with `pipe_last` on tag 2.
- **Level advance and termination:**
  - Level 1 with 5 updates → `pipe_level` = 2 and a new `scan_req`.
  - Level 2 with 0 updates → `done` pulses, `final_level` = 2.
- **MAX_LEVEL = 3:** nonzero updates on every level → stops after level 3 with `final_level` = 3.
- **Coincident events:** `pipe_valid_in` and `pipe_last_in` in the same cycle as the only update → `level_updates` = 1 and the run advances a level.
- **Watchdog (`BFS_SCHED_TIMEOUT_EN`, `TIMEOUT` = 8):** withhold `pipe_last_in` → `err` = 1 and `done` 8 cycles after entering DRAIN; the next `start` clears `err`.
